// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with a per-channel FIFO and packet locking.
// Optional per-channel packet counters are enabled with DEMUX_STREAM_STATS_EN.
module demux_1x2_stream #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic              in_last,
    output logic [DATA_W-1:0] y0_data,
    output logic              y0_valid,
    input  logic              y0_ready,
    output logic              y0_last,
    output logic [DATA_W-1:0] y1_data,
    output logic              y1_valid,
    input  logic              y1_ready,
    output logic              y1_last
`ifdef DEMUX_STREAM_STATS_EN
    ,
    output logic [15:0]       pkt_cnt0,
    output logic [15:0]       pkt_cnt1
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic            lock_ch_q, lock_ch_d;
    logic [DATA_W:0] mem_q [2][DEPTH];
    logic [DATA_W:0] mem_d [2][DEPTH];
    logic [PW-1:0]   wr_ptr_q [2];
    logic [PW-1:0]   wr_ptr_d [2];
    logic [PW-1:0]   rd_ptr_q [2];
    logic [PW-1:0]   rd_ptr_d [2];
    logic [CW-1:0]   cnt_q [2];
    logic [CW-1:0]   cnt_d [2];

    logic       target;
    logic       accept;
    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;

    assign out_ready = {y1_ready, y0_ready};

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        // The lock only governs routing mid-packet; between packets in_sel steers directly.
        target = (state_q == LOCKED) ? lock_ch_q : in_sel;
        for (int c = 0; c < 2; c++) begin
            full[c] = (cnt_q[c] == CW'(DEPTH));
            pop[c]  = (cnt_q[c] != '0) && out_ready[c];
        end
        in_ready = !rst && !full[target];
        accept   = in_valid && in_ready;

        for (int c = 0; c < 2; c++) begin
            push[c] = accept && (target == c[0]);
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = {in_data, in_last};
                wr_ptr_d[c]           = wr_ptr_q[c] + PW'(1);
            end
            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
            end
            cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
        end

        if (accept) begin
            if (state_q == IDLE && !in_last) begin
                state_d   = LOCKED;
                lock_ch_d = in_sel;
            end else if (state_q == LOCKED && in_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_ch_q <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign y0_valid = (cnt_q[0] != '0);
    assign y1_valid = (cnt_q[1] != '0);
    assign y0_data  = mem_q[0][rd_ptr_q[0]][DATA_W:1];
    assign y1_data  = mem_q[1][rd_ptr_q[1]][DATA_W:1];
    assign y0_last  = mem_q[0][rd_ptr_q[0]][0];
    assign y1_last  = mem_q[1][rd_ptr_q[1]][0];

`ifdef DEMUX_STREAM_STATS_EN
    logic [15:0] pkt_cnt_q [2];
    logic [15:0] pkt_cnt_d [2];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            pkt_cnt_d[c] = pkt_cnt_q[c];
            if (pop[c] && mem_q[c][rd_ptr_q[c]][0]) begin
                pkt_cnt_d[c] = pkt_cnt_q[c] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q[0] <= '0;
            pkt_cnt_q[1] <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt0 = pkt_cnt_q[0];
    assign pkt_cnt1 = pkt_cnt_q[1];
`endif

endmodule
